tt_response_checker: RTL and testbench

- Receiving-end counterpart to the exhaustive truth-table stimulus drivers used with the small combinational function blocks (e.g. the a/b/d product-of-sums function).
- Accepts (input vector, observed output) samples over a valid/ready handshake and compares each sample against a golden truth table latched at start.
- Tracks which of the 2^N_IN vectors have been seen, counts mismatches and declares pass/fail once every vector has been covered.
- Sits beside the DUT in self-checking benches and in FPGA bring-up wrappers.

---
 rtl/tt_check_pkg.sv | 18 +
 rtl/tt_misr16.sv | 28 ++
 rtl/tt_response_checker.sv | 125 ++++++++++++
 tb/tb_tt_response_checker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_check_pkg.sv
// Shared types and constants for the truth-table response checker.
// Holds the run state enum, MISR constants and the rows() helper.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic int rows(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_misr16.sv
// Serial 16-bit MISR compacting one bit per enabled cycle.
// Ports: clk, rst_n, en (shift in din), clr (load seed), din, sig.
module tt_misr16
  import tt_check_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        din,
  output logic [15:0] sig
);

  logic fb;

  assign fb = sig[15] ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= 16'h0000;
    end else if (clr) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/tt_response_checker.sv
// Checks (vector, output) samples against a latched golden truth table.
// Ports: clk, rst_n, start, golden, in_valid/in_ready/in_vec/in_y sample
// handshake; busy, done, pass, err_count, first_err_vec, first_err_valid,
// coverage status. Define TT_RESPONSE_CHECKER_SIGNATURE_EN to add a
// 16-bit MISR signature output over accepted in_y bits.
module tt_response_checker
  import tt_check_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int ERR_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [rows(N_IN)-1:0]   golden,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         in_vec,
  input  logic                    in_y,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERR_W-1:0]        err_count,
  output logic [N_IN-1:0]         first_err_vec,
  output logic                    first_err_valid,
  output logic [rows(N_IN)-1:0]   coverage
`ifdef TT_RESPONSE_CHECKER_SIGNATURE_EN
  ,
  output logic [15:0]             signature
`endif
);

  localparam int ROWS = rows(N_IN);

  state_e          state_q;
  state_e          state_d;
  logic [ROWS-1:0] golden_q;
  logic [ROWS-1:0] cov_q;
  logic [ROWS-1:0] cov_set;
  logic [ERR_W-1:0] err_q;
  logic [N_IN-1:0] fvec_q;
  logic            fvalid_q;
  logic            launch;
  logic            accept;
  logic            miss;
  logic            cov_full;

  // start is only honoured outside a run
  assign launch   = start && (state_q != RUN);
  assign accept   = in_valid && in_ready;
  assign cov_set  = cov_q | (ROWS'(1) << in_vec);
  assign cov_full = &cov_set;
  assign miss     = accept && (in_y != golden_q[in_vec]);

  assign in_ready        = (state_q == RUN);
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = done && (err_q == '0);
  assign err_count       = err_q;
  assign first_err_vec   = fvec_q;
  assign first_err_valid = fvalid_q;
  assign coverage        = cov_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && cov_full) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      golden_q <= '0;
      cov_q    <= '0;
      err_q    <= '0;
      fvec_q   <= '0;
      fvalid_q <= 1'b0;
    end else begin
      unique case (1'b1)
        launch: begin
          golden_q <= golden;
          cov_q    <= '0;
          err_q    <= '0;
          fvec_q   <= '0;
          fvalid_q <= 1'b0;
        end
        accept: begin
          cov_q <= cov_set;
          if (miss) begin
            if (err_q != '1) err_q <= err_q + ERR_W'(1);
            // only the first mismatch of a run is recorded
            if (!fvalid_q) begin
              fvec_q   <= in_vec;
              fvalid_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TT_RESPONSE_CHECKER_SIGNATURE_EN
  tt_misr16 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .clr   (launch),
    .din   (in_y),
    .sig   (signature)
  );
`endif

endmodule

// File: tb/tb_tt_response_checker.sv
// Scoreboard bench for tt_response_checker (N_IN=3, ERR_W=4 and ERR_W=2).
// Stimulus pushes expected end-of-run results; a monitor checks on done.
module tb_tt_response_checker;

  typedef struct {
    logic        pass;
    logic [3:0]  err4;
    logic [1:0]  err2;
    logic [2:0]  fvec;
    logic        fvalid;
    logic [7:0]  cov;
    logic [15:0] sig;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] golden = 8'h00;
  logic       in_valid = 1'b0;
  logic [2:0] in_vec = 3'd0;
  logic       in_y = 1'b0;

  logic       rdy_a, busy_a, done_a, pass_a, fvv_a;
  logic [3:0] err_a;
  logic [2:0] fv_a;
  logic [7:0] cov_a;
  logic       rdy_b, busy_b, done_b, pass_b, fvv_b;
  logic [1:0] err_b;
  logic [2:0] fv_b;
  logic [7:0] cov_b;
`ifdef TT_RESPONSE_CHECKER_SIGNATURE_EN
  logic [15:0] sig_a, sig_b;
`endif

  int   ncmp = 0;
  int   nerr = 0;
  exp_t sb[$];
  exp_t mon_x;
  logic done_d = 1'b0;

  always #5 clk = ~clk;

  tt_response_checker #(.N_IN(3), .ERR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .golden(golden),
    .in_valid(in_valid), .in_ready(rdy_a), .in_vec(in_vec), .in_y(in_y),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_vec(fv_a), .first_err_valid(fvv_a), .coverage(cov_a)
`ifdef TT_RESPONSE_CHECKER_SIGNATURE_EN
    , .signature(sig_a)
`endif
  );

  tt_response_checker #(.N_IN(3), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .golden(golden),
    .in_valid(in_valid), .in_ready(rdy_b), .in_vec(in_vec), .in_y(in_y),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_vec(fv_b), .first_err_valid(fvv_b), .coverage(cov_b)
`ifdef TT_RESPONSE_CHECKER_SIGNATURE_EN
    , .signature(sig_b)
`endif
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every rising done pops one expected run result.
  always @(negedge clk) begin
    if (done_a && !done_d) begin
      if (sb.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
      end else begin
        mon_x = sb.pop_front();
        chk("pass", pass_a, mon_x.pass);
        chk("err_count", err_a, mon_x.err4);
        chk("first_err_valid", fvv_a, mon_x.fvalid);
        chk("first_err_vec", fv_a, mon_x.fvec);
        chk("coverage", cov_a, mon_x.cov);
        chk("busy_done", busy_a, 0);
        chk("sat_done", done_b, 1);
        chk("sat_err_count", err_b, mon_x.err2);
        chk("sat_pass", pass_b, mon_x.pass);
`ifdef TT_RESPONSE_CHECKER_SIGNATURE_EN
        chk("signature", sig_a, mon_x.sig);
`endif
      end
    end
    done_d <= done_a;
  end

  // Reference model: totals derived from the sample list in order,
  // stopping at the sample that first completes coverage.
  task automatic do_run(input logic [7:0] g, input int vecs[$],
                        input logic [63:0] flips, input bit stall,
                        input int mid_start);
    exp_t        x;
    logic [7:0]  cov;
    int          e;
    logic [15:0] sig;
    logic        y;
    logic        fb;
    start  = 1'b1;
    golden = g;
    @(negedge clk);
    start  = 1'b0;
    golden = 8'($urandom);
    chk("busy_after_start", busy_a, 1);
    chk("done_after_start", done_a, 0);
    chk("cov_after_start", cov_a, 0);
    cov      = 8'h00;
    e        = 0;
    x.fvalid = 1'b0;
    x.fvec   = 3'd0;
    sig      = 16'hFFFF;
    for (int k = 0; k < vecs.size(); k++) begin
      if (stall) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          in_vec   = 3'($urandom);
          in_y     = 1'($urandom);
          @(negedge clk);
        end
      end
      chk("in_ready", rdy_a, 1);
      y        = g[vecs[k]] ^ flips[k];
      in_vec   = 3'(vecs[k]);
      in_y     = y;
      in_valid = 1'b1;
      if (k == mid_start) begin
        start  = 1'b1;
        golden = ~g;
      end
      @(posedge clk);
      cov[vecs[k]] = 1'b1;
      if (y != g[vecs[k]]) begin
        if (!x.fvalid) begin
          x.fvalid = 1'b1;
          x.fvec   = 3'(vecs[k]);
        end
        e++;
      end
      fb  = sig[15] ^ y;
      sig = {sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      if (cov == 8'hFF) begin
        x.pass = (e == 0);
        x.err4 = 4'((e > 15) ? 15 : e);
        x.err2 = 2'((e > 3) ? 3 : e);
        x.cov  = cov;
        x.sig  = sig;
        sb.push_back(x);
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      if (cov == 8'hFF) begin
        chk("done_latency", done_a, 1);
        chk("ready_drop", rdy_a, 0);
        break;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, rdy_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_err"}, err_a, 0);
    chk({tag, "_fvalid"}, fvv_a, 0);
    chk({tag, "_fvec"}, fv_a, 0);
    chk({tag, "_cov"}, cov_a, 0);
`ifdef TT_RESPONSE_CHECKER_SIGNATURE_EN
    chk({tag, "_sig"}, sig_a, 0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seq[$];
    int          p[8];
    int          t;
    int          j;
    logic [63:0] fl;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_ignores_valid", cov_a, 0);

    seq = {0, 1, 2, 3, 4, 5, 6, 7};
    do_run(8'b1011_0010, seq, 64'h0, 1'b0, -1);
    do_run(8'b1011_0010, seq, 64'h0, 1'b0, -1);
    do_run(8'b1011_0010, seq, 64'h20, 1'b0, -1);

    seq = {0, 0, 3, 3, 1, 2, 4, 5, 6, 7};
    do_run(8'b0110_1001, seq, 64'h0, 1'b1, -1);

    seq = {0, 1, 2, 5, 3, 4, 6, 7};
    do_run(8'h5A, seq, 64'hFF, 1'b0, -1);

    seq = {7, 6, 5, 4, 3, 2, 1, 0};
    do_run(8'hC3, seq, 64'h4, 1'b0, 4);

    for (int r = 0; r < 8; r++) begin
      seq = {};
      repeat ($urandom_range(0, 6)) seq.push_back($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) p[i] = i;
      for (int i = 7; i > 0; i--) begin
        j    = $urandom_range(0, i);
        t    = p[i];
        p[i] = p[j];
        p[j] = t;
      end
      for (int i = 0; i < 8; i++) seq.push_back(p[i]);
      fl = 64'h0;
      for (int i = 0; i < 64; i++) fl[i] = ($urandom_range(0, 7) == 0);
      do_run(8'($urandom), seq, fl, r[0], (r == 3) ? 2 : -1);
    end

    // Reset in the middle of a run with errors already logged.
    start  = 1'b1;
    golden = 8'hF0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vec   = 3'(i);
      in_y     = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_reset_err", err_a, 3);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", rdy_a, 0);

    seq = {3, 1, 4, 0, 5, 2, 6, 7};
    do_run(8'h96, seq, 64'h0, 1'b1, -1);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
